// File: rtl/pixel_stream_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_pkg
// Purpose  : Shared types and helpers for the pixel stream serializer.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic int calc_beats(input int pixel_w, input int out_w);
        return pixel_w / out_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_stream_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_if
// Purpose  : Pixel-in / beat-out stream bundle for the serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_stream_if #(
    parameter int PIXEL_W = 8,
    parameter int OUT_W   = 2
);
    logic               in_valid;
    logic [PIXEL_W-1:0] in_pixel;
    logic               in_ready;
    logic               stall;
    logic               axiov;
    logic [OUT_W-1:0]   axiod;
    logic               axiol;

    modport slave (
        input  in_valid, in_pixel, stall,
        output in_ready, axiov, axiod, axiol
    );

    modport master (
        output in_valid, in_pixel, stall,
        input  in_ready, axiov, axiod, axiol
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_serializer_shifter.sv
`default_nettype none
// ============================================================================
// Module   : beat_shifter
// Purpose  : Pixel shift register presenting one OUT_W beat at a time.
// Revision : 1.0 - initial release
// ============================================================================
module beat_shifter #(
    parameter int PIXEL_W = 8,
    parameter int OUT_W   = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_load,
    input  wire logic               i_shift,
    input  wire logic               i_lsb_first,
    input  wire logic [PIXEL_W-1:0] i_data,
    output logic      [OUT_W-1:0]   o_slice
);
    localparam int c_beats = PIXEL_W / OUT_W;

    logic [PIXEL_W-1:0] r_sreg;
    logic [PIXEL_W-1:0] w_ordered;

    // LSB-first pixels are stored beat-reversed so the output is always the
    // top slice of a register and only one shift direction is needed.
    generate
        for (genvar g = 0; g < c_beats; g++) begin : g_beat_rev
            assign w_ordered[PIXEL_W-1-g*OUT_W -: OUT_W] = i_lsb_first
                ? i_data[g*OUT_W +: OUT_W]
                : i_data[PIXEL_W-1-g*OUT_W -: OUT_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= w_ordered;
        end else if (i_shift) begin
            r_sreg <= r_sreg << OUT_W;
        end
    end

    assign o_slice = r_sreg[PIXEL_W-1 -: OUT_W];
endmodule
`default_nettype wire

// File: rtl/pixel_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_serializer
// Purpose  : Serialises pixels into OUT_W beats, packetised with idle gaps.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_stream_serializer
    import pixel_stream_pkg::*;
#(
    parameter int PIXEL_W       = 8,
    parameter int OUT_W         = 2,
    parameter int PACKET_PIXELS = 160,
    parameter int IMAGE_PIXELS  = 76800,
    parameter int ADDR_W        = 17,
    parameter int GAP_CYCLES    = 48
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              enable,
    input  wire logic              lsb_first,
    pixel_stream_if.slave          bus,
    output logic      [ADDR_W-1:0] pixel_addr,
    output logic                   frame_done,
    output logic                   busy
);
    localparam int c_beats  = calc_beats(PIXEL_W, OUT_W);
    localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_pkt_w  = $clog2(PACKET_PIXELS + 1);
    localparam int c_gap_w  = $clog2(GAP_CYCLES + 1);

    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);
    localparam logic [c_pkt_w-1:0]  c_last_pix  = c_pkt_w'(PACKET_PIXELS - 1);
    localparam logic [c_gap_w-1:0]  c_gap_load  = c_gap_w'(GAP_CYCLES);
    localparam logic [ADDR_W-1:0]   c_addr_max  = ADDR_W'(IMAGE_PIXELS - 1);

    state_t              r_state, w_state_nxt;
    logic [c_beat_w-1:0] r_beat, w_beat_nxt;
    logic [c_pkt_w-1:0]  r_pkt, w_pkt_nxt;
    logic [c_gap_w-1:0]  r_gap, w_gap_nxt;
    logic                r_mode, w_mode_nxt;
    logic                r_axiov, r_axiol, r_frame_done;
    logic [ADDR_W-1:0]   r_pixel_addr;
    logic                w_load, w_shift, w_xfer, w_accept, w_in_ready;
    logic                w_last_beat, w_last_pix;
    logic [OUT_W-1:0]    w_slice;

    assign w_xfer      = r_axiov && !bus.stall;
    assign w_last_beat = (r_beat == c_last_beat);
    assign w_last_pix  = (r_pkt == c_last_pix);
    assign w_in_ready  = (r_state == ST_IDLE && enable) || (r_state == ST_WAIT) ||
                         (r_state == ST_SEND && w_last_beat && !bus.stall && !w_last_pix);
    assign w_accept    = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_pkt        <= '0;
            r_gap        <= '0;
            r_mode       <= 1'b0;
            r_axiov      <= 1'b0;
            r_axiol      <= 1'b0;
            r_frame_done <= 1'b0;
            r_pixel_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_pkt        <= w_pkt_nxt;
            r_gap        <= w_gap_nxt;
            r_mode       <= w_mode_nxt;
            r_axiov      <= (w_state_nxt == ST_SEND);
            r_axiol      <= (w_state_nxt == ST_SEND) && (w_beat_nxt == c_last_beat) &&
                            (w_pkt_nxt == c_last_pix);
            r_frame_done <= w_accept && (r_pixel_addr == c_addr_max);
            if (w_accept) begin
                r_pixel_addr <= (r_pixel_addr == c_addr_max) ? '0 : r_pixel_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_pkt_nxt   = r_pkt;
        w_gap_nxt   = r_gap;
        w_mode_nxt  = r_mode;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                    w_beat_nxt  = '0;
                    w_pkt_nxt   = '0;
                    w_mode_nxt  = lsb_first;
                    w_load      = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (!w_last_beat) begin
                        w_shift    = 1'b1;
                        w_beat_nxt = r_beat + 1'b1;
                    end else if (w_last_pix) begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = c_gap_load;
                    end else if (w_accept) begin
                        w_load     = 1'b1;
                        w_beat_nxt = '0;
                        w_pkt_nxt  = r_pkt + 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                    w_load      = 1'b1;
                    w_beat_nxt  = '0;
                    w_pkt_nxt   = r_pkt + 1'b1;
                end
            end
            ST_GAP: begin
                w_gap_nxt = r_gap - 1'b1;
                if (r_gap == c_gap_w'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    beat_shifter #(
        .PIXEL_W (PIXEL_W),
        .OUT_W   (OUT_W)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_shift     (w_shift),
        .i_lsb_first (w_mode_nxt),
        .i_data      (bus.in_pixel),
        .o_slice     (w_slice)
    );

    assign bus.in_ready = w_in_ready && !rst;
    assign bus.axiov    = r_axiov;
    assign bus.axiod    = w_slice;
    assign bus.axiol    = r_axiol;
    assign pixel_addr   = r_pixel_addr;
    assign frame_done   = r_frame_done;
    assign busy         = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_serializer
// Purpose  : Scoreboard bench for pixel_stream_serializer (small packets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_serializer;
    localparam int PIXEL_W       = 8;
    localparam int OUT_W         = 2;
    localparam int PACKET_PIXELS = 4;
    localparam int IMAGE_PIXELS  = 6;
    localparam int ADDR_W        = 3;
    localparam int GAP_CYCLES    = 3;
    localparam int BEATS         = PIXEL_W / OUT_W;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              lsb_first;
    logic [ADDR_W-1:0] pixel_addr;
    logic              frame_done;
    logic              busy;

    pixel_stream_if #(.PIXEL_W(PIXEL_W), .OUT_W(OUT_W)) bus ();

    pixel_stream_serializer #(
        .PIXEL_W       (PIXEL_W),
        .OUT_W         (OUT_W),
        .PACKET_PIXELS (PACKET_PIXELS),
        .IMAGE_PIXELS  (IMAGE_PIXELS),
        .ADDR_W        (ADDR_W),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .lsb_first  (lsb_first),
        .bus        (bus),
        .pixel_addr (pixel_addr),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_cyc    = 0;
    int    xfer_count = 0;
    int    fd_count = 0;
    int    m_pkt_idx = 0;
    int    m_addr = 0;
    logic  m_mode = 1'b0;
    logic  m_fd_exp = 1'b0;
    logic  last_acc = 1'b0;

    // One clock cycle: score the visible beat, model any accepted pixel.
    task automatic tick();
        beat_t              exp_b;
        logic               fd_next;
        logic [PIXEL_W-1:0] p;
        #3;
        n_cyc++;
        n_checks++;
        if (frame_done !== m_fd_exp) begin
            n_fail++;
            $display("FAIL frame_done: got %b expected %b", frame_done, m_fd_exp);
        end
        if (frame_done === 1'b1) fd_count++;
        if (bus.axiov === 1'b1 && bus.stall === 1'b0) begin
            xfer_count++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got data %b last %b, expected no beat", bus.axiod, bus.axiol);
            end else begin
                exp_b = sb_q.pop_front();
                if (bus.axiod !== exp_b.data || bus.axiol !== exp_b.last) begin
                    n_fail++;
                    $display("FAIL beat: got data %b last %b expected data %b last %b",
                             bus.axiod, bus.axiol, exp_b.data, exp_b.last);
                end
            end
        end
        last_acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        fd_next  = 1'b0;
        if (last_acc) begin
            n_checks++;
            if (pixel_addr !== ADDR_W'(m_addr)) begin
                n_fail++;
                $display("FAIL accept_addr: got %0d expected %0d", pixel_addr, m_addr);
            end
            if (m_pkt_idx == 0) m_mode = lsb_first;
            p = bus.in_pixel;
            for (int k = 0; k < BEATS; k++) begin
                exp_b.data = m_mode ? OUT_W'(p >> (k * OUT_W))
                                    : OUT_W'(p >> (PIXEL_W - OUT_W - k * OUT_W));
                exp_b.last = (m_pkt_idx == PACKET_PIXELS - 1) && (k == BEATS - 1);
                sb_q.push_back(exp_b);
            end
            fd_next   = (m_addr == IMAGE_PIXELS - 1);
            m_addr    = (m_addr + 1) % IMAGE_PIXELS;
            m_pkt_idx = (m_pkt_idx + 1) % PACKET_PIXELS;
        end
        @(posedge clk);
        #1;
        m_fd_exp = fd_next;
    endtask

    task automatic drive_pixel(input logic [PIXEL_W-1:0] pix);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pixel = pix;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = last_acc;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: pixel %h not accepted in 100 cycles", pix);
        end
    endtask

    task automatic drain();
        bit idle = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            tick();
            idle = (busy === 1'b0);
        end
        n_checks++;
        if (!idle || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got idle %b with %0d beats outstanding, expected idle 1 with 0",
                     idle, sb_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        m_pkt_idx = 0;
        m_addr    = 0;
        m_fd_exp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        enable       = 1'b1;
        lsb_first    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'hA5;
        bus.stall    = 1'b0;
        rst          = 1'b1;
        #3;
        n_checks++;
        if ({bus.in_ready, bus.axiov, bus.axiod, bus.axiol, pixel_addr, frame_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy %b v %b d %b l %b addr %0d fd %b busy %b expected all 0",
                     bus.in_ready, bus.axiov, bus.axiod, bus.axiol, pixel_addr, frame_done, busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.axiov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got in_ready %b axiov %b expected 0 0", bus.in_ready, bus.axiov);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got in_ready %b busy %b expected 1 0", bus.in_ready, busy);
        end
    endtask

    task automatic test_msb_order();
        int cyc_first, xfer_first, g;
        bit seen;
        lsb_first = 1'b0;
        drive_pixel(8'hA5);
        n_checks++;
        if (bus.axiov !== 1'b1 || bus.axiod !== 2'b10) begin
            n_fail++;
            $display("FAIL msb_first_beat: got v %b d %b expected 1 10", bus.axiov, bus.axiod);
        end
        cyc_first  = n_cyc;
        xfer_first = xfer_count;
        drive_pixel(8'h3C);
        drive_pixel(8'hFF);
        drive_pixel(8'h00);
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            seen = (bus.axiov === 1'b1 && bus.axiol === 1'b1);
            if (!seen) tick();
        end
        n_checks++;
        if (!seen || (n_cyc - cyc_first) != 15 || (xfer_count - xfer_first) != 15) begin
            n_fail++;
            $display("FAIL msb_burst: got last seen %b after %0d cycles %0d beats expected 15 15",
                     seen, n_cyc - cyc_first, xfer_count - xfer_first);
        end
        tick();
        g = 0;
        while (busy === 1'b1 && bus.axiov === 1'b0 && g < 20) begin
            tick();
            g++;
        end
        n_checks++;
        if (g != GAP_CYCLES || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_len: got %0d gap cycles busy %b rdy %b expected %0d 0 1",
                     g, busy, bus.in_ready, GAP_CYCLES);
        end
    endtask

    task automatic test_lsb_order();
        lsb_first = 1'b1;
        drive_pixel(8'hA5);
        n_checks++;
        if (bus.axiov !== 1'b1 || bus.axiod !== 2'b01) begin
            n_fail++;
            $display("FAIL lsb_first_beat: got v %b d %b expected 1 01", bus.axiov, bus.axiod);
        end
        drive_pixel(8'h3C);
        drive_pixel(8'hFF);
        drive_pixel(8'h00);
        drain();
    endtask

    task automatic test_stall();
        lsb_first = 1'b0;
        drive_pixel(8'hA5);
        bus.in_pixel = 8'h3C;
        tick();
        bus.stall = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.axiov !== 1'b1 || bus.axiod !== 2'b10 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got v %b d %b rdy %b expected 1 10 0",
                         i, bus.axiov, bus.axiod, bus.in_ready);
            end
            tick();
        end
        bus.stall = 1'b0;
        drive_pixel(8'h3C);
        drive_pixel(8'hFF);
        drive_pixel(8'h00);
        drain();
    endtask

    task automatic test_starvation();
        bit waiting = 1'b0;
        lsb_first = 1'b1;
        drive_pixel(8'h1B);
        lsb_first = 1'b0;
        drive_pixel(8'hE4);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !waiting; i++) begin
            waiting = (busy === 1'b1 && bus.axiov === 1'b0);
            if (!waiting) tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.axiov !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_state: cycle %0d got v %b rdy %b busy %b expected 0 1 1",
                         i, bus.axiov, bus.in_ready, busy);
            end
            tick();
        end
        drive_pixel(8'h2D);
        n_checks++;
        if (bus.axiov !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_resume: got axiov %b expected 1", bus.axiov);
        end
        drive_pixel(8'h78);
        drain();
    endtask

    task automatic test_addr_wrap();
        do_reset();
        fd_count  = 0;
        lsb_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_pixel(PIXEL_W'(i * 37 + 11));
            n_checks++;
            if (pixel_addr !== ADDR_W'((i + 1) % IMAGE_PIXELS)) begin
                n_fail++;
                $display("FAIL addr_seq: pixel %0d got %0d expected %0d", i, pixel_addr, (i + 1) % IMAGE_PIXELS);
            end
        end
        drain();
        n_checks++;
        if (fd_count != 1) begin
            n_fail++;
            $display("FAIL frame_done_count: got %0d expected 1", fd_count);
        end
    endtask

    task automatic test_reset_mid_packet();
        int cyc_first;
        bit seen;
        lsb_first = 1'b0;
        drive_pixel(8'hC3);
        drive_pixel(8'h5A);
        bus.in_pixel = 8'h99;
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.axiov, bus.axiod, bus.axiol, pixel_addr, frame_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got rdy %b v %b d %b l %b addr %0d fd %b busy %b expected all 0",
                     bus.in_ready, bus.axiov, bus.axiod, bus.axiol, pixel_addr, frame_done, busy);
        end
        sb_q.delete();
        m_pkt_idx = 0;
        m_addr    = 0;
        m_fd_exp  = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_pixel(8'h81);
        n_checks++;
        if (pixel_addr !== ADDR_W'(1)) begin
            n_fail++;
            $display("FAIL post_reset_addr: got %0d expected 1", pixel_addr);
        end
        cyc_first = n_cyc;
        drive_pixel(8'h42);
        drive_pixel(8'hE7);
        drive_pixel(8'h18);
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            seen = (bus.axiov === 1'b1 && bus.axiol === 1'b1);
            if (!seen) tick();
        end
        n_checks++;
        if (!seen || (n_cyc - cyc_first) != 15) begin
            n_fail++;
            $display("FAIL post_reset_packet: got last seen %b at beat %0d expected beat 16",
                     seen, n_cyc - cyc_first + 1);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_msb_order();
        test_lsb_order();
        test_stall();
        test_starvation();
        test_addr_wrap();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/pixel_stream_serializer.md
# pixel_stream_serializer

Parametrised successor to the pixel-to-dibit bit-order stage feeding `eth_packer`. Accepts whole pixels over a valid/ready handshake and emits them as OUT_W-bit beats, MSB-first or LSB-first (selectable per packet). It obeys `eth_packer`'s `stall`, cuts the stream into fixed-size packets with an end-of-packet marker and a minimum idle gap, and tracks the image read address with wrap-around.

## Interface
- PIXEL_W, 8, pixel width in bits; must be a multiple of OUT_W.
- OUT_W, 2, output beat width; RMII dibit by default.
- PACKET_PIXELS, 160, pixels per packet; must be at least 1.
- IMAGE_PIXELS, 76800, pixels per image; `pixel_addr` wraps after IMAGE_PIXELS-1.
- ADDR_W, 17, `pixel_addr` width; must satisfy 2^ADDR_W >= IMAGE_PIXELS.
- GAP_CYCLES, 48, idle cycles forced after each packet; must be at least 1.
- clk  in  1  single clock domain.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  permits starting a new packet; a packet in progress always completes.
- lsb_first  in  1  bit-order mode, sampled when a packet's first pixel is accepted.
- in_valid  in  1  `in_pixel` is valid.
- in_pixel  in  PIXEL_W  pixel data.
- in_ready  out  1  pixel accepted on a cycle where in_valid && in_ready.
- stall  in  1  downstream not accepting; a beat transfers only when axiov && !stall.
- axiov  out  1  beat valid.
- axiod  out  OUT_W  beat data.
- axiol  out  1  last beat of the packet; qualified by axiov.
- pixel_addr  out  ADDR_W  image address of the next pixel to be accepted.
- frame_done  out  1  one-cycle pulse, registered, the cycle after the pixel at IMAGE_PIXELS-1 is accepted.
- busy  out  1  state is not IDLE.

## Operation
- BEATS = PIXEL_W/OUT_W beats per pixel.
- States:
  - IDLE: axiov=0; in_ready=enable.
  - SEND: axiov=1.
  - WAIT: axiov=0; in_ready=1.
  - GAP: axiov=0; in_ready=0.
- Accepting a pixel in IDLE or WAIT:
  - Load the shift register and clear the beat counter; go to SEND.
  - In IDLE only: latch lsb_first and clear the packet pixel count.
- MSB-first:
  - axiod = sreg[PIXEL_W-1 -: OUT_W]; shift left by OUT_W per transferred beat.
  - 0xA5 gives beats 10,10,01,01.
- LSB-first:
  - axiod = sreg[OUT_W-1:0]; shift right by OUT_W per transferred beat.
  - 0xA5 gives beats 01,01,10,10.
- SEND, transferred beat that is not beat BEATS-1: shift the register and increment the beat counter.
- SEND, transferred beat BEATS-1, last pixel of the packet:
  - axiol=1 on this beat.
  - Go to GAP and load the gap counter with GAP_CYCLES.
- SEND, transferred beat BEATS-1, other pixels:
  - in_ready=1 on this cycle.
  - If in_valid: load the next pixel and stay in SEND with no bubble.
  - Otherwise go to WAIT.
- In SEND, in_ready is combinational from stall: in_ready = state==SEND && beat==BEATS-1 && !stall && !last_pixel_of_packet.
- GAP: decrement the counter each cycle; at 1, go to IDLE. The packet-start mode is used for every beat of that packet.
- Each accepted pixel increments pixel_addr; IMAGE_PIXELS-1 wraps to 0. Packets may straddle the image boundary; the packet count is independent of pixel_addr.
- enable falling mid-packet: no effect until IDLE; IDLE then holds with in_ready=0.
- Arithmetic widths:
  - Beat counter: $clog2(BEATS) bits; BEATS=1 is legal, every beat is the last beat.
  - Packet counter: $clog2(PACKET_PIXELS+1) bits.
  - Gap counter: $clog2(GAP_CYCLES+1) bits.

## Timing
- Reset (asynchronous, immediate at any point including mid-packet):
  - state=IDLE; axiov=0, axiod=0, axiol=0, in_ready=0, pixel_addr=0, frame_done=0, busy=0.
  - Counters and sreg clear; a partial packet is discarded with no axiol.
  - in_ready is forced 0 while rst is high.
- First beat appears on axiov the cycle after acceptance from IDLE or WAIT.
- axiod, axiov and axiol are driven from registers only.
- Under stall, axiod, axiov and axiol hold stable; stall in IDLE, WAIT or GAP has no effect.
- Peak throughput: PACKET_PIXELS*BEATS consecutive beats, then GAP_CYCLES idle, then at least 1 IDLE cycle before the next packet's first beat.

## Structure
- Package `pixel_stream_pkg`:
  - state enum typedef (IDLE, SEND, WAIT, GAP).
  - Helper localparam function for BEATS.
- Sub-module `beat_shifter`: load, shift enable and mode in; current slice out. Parametrised by PIXEL_W and OUT_W.
- Top module holds the FSM, all counters and pixel_addr.

## Test plan
All scenarios use PIXEL_W=8, OUT_W=2, PACKET_PIXELS=4, IMAGE_PIXELS=6, GAP_CYCLES=3.
- MSB order: enable=1, lsb_first=0, in_valid=1 with pixels 0xA5,0x3C,0xFF,0x00 → 16 consecutive beats 10,10,01,01,00,11,11,00,11,11,11,11,00,00,00,00; axiol on beat 16 only; 3 GAP cycles.
- LSB order: same stimulus with lsb_first=1 → first pixel's beats are 01,01,10,10.
- Stall: stall high for 5 cycles on beat 2 → axiod=10, axiov=1 held all 5 cycles; no beat lost or duplicated; in_ready stays 0.
- Starvation: in_valid low for 4 cycles after pixel 2 → WAIT with axiov=0, in_ready=1; resumes the cycle after in_valid returns.
- Address wrap: two packets → pixel_addr sequence 0..5,0,1 then 2; frame_done pulses once after the pixel at address 5 is accepted.
- Reset mid-packet: rst asserted at beat 6 → all outputs 0 in the same cycle; after release, first accepted pixel gives pixel_addr=1 and a fresh packet with axiol after 16 beats.
